// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM state codes and
// a helper giving the byte count of an access.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Big-endian lane logic: splices store data into a memory word and extracts
// and extends load data from it. Purely combinational.
module lsu_lane_merge
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] load_val
);

  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  // Offset 0 is the most significant lane, so the shift counts down from the top.
  always_comb begin
    shamt     = 5'd0;
    lane_mask = 32'hffff_ffff;
    case (size)
      SZ_BYTE: begin
        shamt     = {2'd3 - offset, 3'b000};
        lane_mask = 32'h0000_00ff;
      end
      SZ_HALF: begin
        shamt     = {2'd2 - {offset[1], 1'b0}, 3'b000};
        lane_mask = 32'h0000_ffff;
      end
      default: begin
        shamt     = 5'd0;
        lane_mask = 32'hffff_ffff;
      end
    endcase
  end

  assign lane_data = (word >> shamt) & lane_mask;
  assign merged    = (word & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);

  always_comb begin
    load_val = lane_data;
    case (size)
      SZ_BYTE: load_val = {{24{sign_ext & lane_data[7]}}, lane_data[7:0]};
      SZ_HALF: load_val = {{16{sign_ext & lane_data[15]}}, lane_data[15:0]};
      default: load_val = lane_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, drives a word-wide data memory with
// sub-word read-modify-write, sign/zero extension and alignment/range faults.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_write_enabled,
  output logic              mem_read_enabled,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_input,
  input  logic [DATA_W-1:0] mem_data_output
);

  logic [1:0]        state;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_fault;

  logic [2:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              fault;
  logic [31:0]       merged;
  logic [31:0]       load_val;

  // One extra bit so an access near the top of the address space cannot wrap.
  assign nbytes   = size_bytes(req_size);
  assign end_addr = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, nbytes};
  assign fault    = (req_size == SZ_ILL)
                 || (req_size == SZ_HALF && req_addr[0])
                 || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                 || (end_addr > (ADDR_W+1)'(MEM_BYTES));

  lsu_lane_merge u_lane_merge (
    .word     (mem_data_output),
    .offset   (r_off),
    .size     (r_size),
    .wdata    (r_wdata),
    .sign_ext (r_signed),
    .merged   (merged),
    .load_val (load_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      r_write        <= 1'b0;
      r_size         <= SZ_BYTE;
      r_signed       <= 1'b0;
      r_off          <= 2'b00;
      r_wdata        <= '0;
      r_rdata        <= '0;
      r_fault        <= 1'b0;
      mem_address    <= '0;
      mem_data_input <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            r_fault  <= fault;
            if (fault) begin
              state <= ST_RESP;
            end else begin
              mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_write && req_size == SZ_WORD) begin
                mem_data_input <= req_wdata;
                state          <= ST_WR;
              end else begin
                state <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (r_write) begin
            mem_data_input <= merged;
            state          <= ST_WR;
          end else begin
            r_rdata <= load_val;
            state   <= ST_RESP;
          end
        end
        ST_WR:   state <= ST_RESP;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready         = (state == ST_IDLE);
  assign mem_read_enabled  = (state == ST_RD);
  assign mem_write_enabled = (state == ST_WR);
  assign resp_valid        = (state == ST_RESP);
  assign resp_fault        = (state == ST_RESP) && r_fault;
  assign resp_rdata        = (state == ST_RESP) ? r_rdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, scoreboard of expected
// responses (data, fault, arrival cycle) checked by a response monitor.
module tb_load_store_unit;

  localparam int MEM_BYTES = 1024;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_write_enabled;
  logic        mem_read_enabled;
  logic [31:0] mem_address;
  logic [31:0] mem_data_input;
  logic [31:0] mem_data_output;

  load_store_unit #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(MEM_BYTES)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_size          (req_size),
    .req_signed        (req_signed),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_fault        (resp_fault),
    .mem_write_enabled (mem_write_enabled),
    .mem_read_enabled  (mem_read_enabled),
    .mem_address       (mem_address),
    .mem_data_input    (mem_data_input),
    .mem_data_output   (mem_data_output)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [256];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  int          n_resp = 0;
  int          n_acc = 0;
  int          wr_seen_cyc = -1;
  logic [31:0] wr_seen_data = '0;
  int          last_drv = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_output = mem[mem_address[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enabled) mem[mem_address[9:2]] <= mem_data_input;
    if (req_valid && req_ready) n_acc = n_acc + 1;
  end

  // Response monitor: every resp_valid must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (mem_write_enabled) begin
      wr_seen_cyc  = cyc;
      wr_seen_data = mem_data_input;
      n_wr++;
    end
    if (mem_read_enabled) n_rd++;
    if (mem_write_enabled && mem_read_enabled) begin
      n_checks++;
      $display("FAIL strobes: read and write both high at cycle %0d", cyc);
    end
    if (resp_valid) begin
      n_resp++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL resp_unexpected: rdata=%h fault=%b at cycle %0d, none expected",
                 resp_rdata, resp_fault, cyc);
      end else begin
        e = sb.pop_front();
        if (resp_rdata !== e.rdata || resp_fault !== e.fault || cyc !== e.cyc)
          $display("FAIL resp: got rdata=%h fault=%b cyc=%0d, want rdata=%h fault=%b cyc=%0d",
                   resp_rdata, resp_fault, cyc, e.rdata, e.fault, e.cyc);
        else
          n_pass++;
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_fault, input int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL ready_timeout: req_ready=%b, want 1", req_ready);
    end
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    last_drv   = cyc;
    sb.push_back('{exp_rdata, exp_fault, cyc + lat});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL resp_timeout: %0d responses outstanding, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0 ||
        mem_write_enabled !== 1'b0 || mem_read_enabled !== 1'b0 ||
        resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_data_input !== 32'h0)
      $display("FAIL reset_outputs: rdy=%b rv=%b rf=%b we=%b re=%b rd=%h a=%h d=%h, want 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_fault, mem_write_enabled, mem_read_enabled,
               resp_rdata, mem_address, mem_data_input);
    else
      n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    wait_idle();
    n_checks++;
    if (wr_seen_cyc !== last_drv + 1 || wr_seen_data !== 32'hDEADBEEF || mem[16] !== 32'hDEADBEEF)
      $display("FAIL word_store: wr_cyc=%0d data=%h mem=%h, want cyc=%0d data=deadbeef",
               wr_seen_cyc, wr_seen_data, mem[16], last_drv + 1);
    else
      n_pass++;
    do_req(1'b0, 2'd2, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    wait_idle();
  endtask

  task automatic test_byte();
    mem[16] = 32'h11223344;
    do_req(1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 32'h00000022, 1'b0, 2);
    do_req(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'h00000011, 1'b0, 2);
    wait_idle();
    do_req(1'b1, 2'd0, 1'b0, 32'h43, 32'hFFFFFF80, 32'h0, 1'b0, 3);
    wait_idle();
    n_checks++;
    if (wr_seen_cyc !== last_drv + 2 || wr_seen_data !== 32'h11223380)
      $display("FAIL byte_store: wr_cyc=%0d data=%h, want cyc=%0d data=11223380",
               wr_seen_cyc, wr_seen_data, last_drv + 2);
    else
      n_pass++;
    do_req(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    do_req(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 32'h00000080, 1'b0, 2);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h11223380, 1'b0, 2);
    wait_idle();
  endtask

  task automatic test_half();
    mem[16] = 32'h11223344;
    do_req(1'b1, 2'd1, 1'b0, 32'h42, 32'h0000ABCD, 32'h0, 1'b0, 3);
    wait_idle();
    n_checks++;
    if (wr_seen_data !== 32'h1122ABCD || mem[16] !== 32'h1122ABCD)
      $display("FAIL half_store: data=%h mem=%h, want 1122abcd", wr_seen_data, mem[16]);
    else
      n_pass++;
    do_req(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 32'h0000ABCD, 1'b0, 2);
    do_req(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 32'hFFFFABCD, 1'b0, 2);
    do_req(1'b0, 2'd1, 1'b1, 32'h40, 32'h0, 32'h00001122, 1'b0, 2);
    wait_idle();
  endtask

  task automatic test_faults();
    int rd0, wr0;
    rd0 = n_rd;
    wr0 = n_wr;
    do_req(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'd1, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1, 1);
    do_req(1'b1, 2'd3, 1'b0, 32'h40, 32'h5A5A5A5A, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'd2, 1'b0, MEM_BYTES - 2, 32'h0, 32'h0, 1'b1, 1);
    do_req(1'b1, 2'd0, 1'b0, MEM_BYTES, 32'h12, 32'h0, 1'b1, 1);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h12, 32'h0, 1'b1, 1);
    wait_idle();
    n_checks++;
    if (n_rd !== rd0 || n_wr !== wr0)
      $display("FAIL fault_strobes: reads=%0d writes=%0d, want 0 0", n_rd - rd0, n_wr - wr0);
    else
      n_pass++;
    mem[255] = 32'h0BADCAFE;
    do_req(1'b0, 2'd2, 1'b0, MEM_BYTES - 4, 32'h0, 32'h0BADCAFE, 1'b0, 2);
    do_req(1'b0, 2'd0, 1'b1, MEM_BYTES - 1, 32'h0, 32'hFFFFFFFE, 1'b0, 2);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic        t_wr[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  t_sz[5]  = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd2};
    logic [31:0] t_ad[5]  = '{32'h100, 32'h101, 32'h101, 32'h100, 32'h100};
    logic [31:0] t_wd[5]  = '{32'h0A0B0C0D, 32'h0, 32'h0, 32'h00007777, 32'h0};
    logic [31:0] t_rd[5]  = '{32'h0, 32'h0000000B, 32'h0, 32'h0, 32'h77770C0D};
    logic        t_ft[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          t_lat[5] = '{2, 2, 1, 3, 2};
    int acc0, resp0, bad;
    acc0  = n_acc;
    resp0 = n_resp;
    bad   = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      while (!req_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      req_write  = t_wr[i];
      req_size   = t_sz[i];
      req_signed = 1'b0;
      req_addr   = t_ad[i];
      req_wdata  = t_wd[i];
      req_valid  = 1'b1;
      sb.push_back('{t_rd[i], t_ft[i], cyc + t_lat[i]});
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (req_ready !== 1'b0) bad++;
      end while (!resp_valid && n < 10);
    end
    req_valid = 1'b0;
    wait_idle();
    n_checks++;
    if (bad != 0)
      $display("FAIL b2b_ready: req_ready high %0d times while busy, want 0", bad);
    else
      n_pass++;
    n_checks++;
    if (n_acc - acc0 !== 5 || n_resp - resp0 !== 5)
      $display("FAIL b2b_count: accepts=%0d responses=%0d, want 5 5", n_acc - acc0, n_resp - resp0);
    else
      n_pass++;
  endtask

  task automatic test_reset_mid_rmw();
    int wr0;
    mem[32] = 32'hCAFEF00D;
    wr0 = n_wr;
    @(negedge clk);
    req_write  = 1'b1;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h81;
    req_wdata  = 32'h55;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (mem_read_enabled !== 1'b1 || mem_address !== 32'h80)
      $display("FAIL rmw_read: re=%b addr=%h, want 1 00000080", mem_read_enabled, mem_address);
    else
      n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0 ||
        mem_write_enabled !== 1'b0 || mem_read_enabled !== 1'b0 ||
        resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_data_input !== 32'h0)
      $display("FAIL async_reset: rdy=%b rv=%b rf=%b we=%b re=%b rd=%h a=%h d=%h, want 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_fault, mem_write_enabled, mem_read_enabled,
               resp_rdata, mem_address, mem_data_input);
    else
      n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (n_wr !== wr0 || mem[32] !== 32'hCAFEF00D)
      $display("FAIL reset_no_write: writes=%0d mem=%h, want 0 cafef00d", n_wr - wr0, mem[32]);
    else
      n_pass++;
    do_req(1'b1, 2'd0, 1'b0, 32'h81, 32'h55, 32'h0, 1'b0, 3);
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hCA55F00D, 1'b0, 2);
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_faults();
    test_back_to_back();
    test_reset_mid_rmw();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
